// File: rtl/inst_slot_queue_pkg.sv
// rtl/inst_slot_queue_pkg.sv - shared instruction type and sizing constants for the slot queue
//
// Purpose : instruction width and the inst_t type used by the queue, its
//           write mux and its handshake interface.
// Ports   : none (package).
package inst_slot_queue_pkg;

    // Instruction width; fixed for the whole fetch path, not overridden per instance.
    localparam int INST_LENGTH = 32;

    // Default number of instruction slots.
    localparam int DEFAULT_SLOT = 8;

    typedef logic [INST_LENGTH-1:0] inst_t;

endpackage

// File: rtl/inst_slot_queue_if.sv
// rtl/inst_slot_queue_if.sv - enqueue/dequeue handshake bundle for the instruction slot queue
//
// Purpose : groups flush, the enqueue (in_*) and dequeue (out_*) handshakes and
//           the occupancy count into one bundle.
// Ports   : master - upstream/downstream side: drives flush, in_valid, in_inst,
//                    out_ready; observes in_ready, out_valid, out_inst, count.
//           slave  - the queue itself, directions reversed.
interface inst_slot_queue_if
    import inst_slot_queue_pkg::*;
#(
    parameter int SLOT = DEFAULT_SLOT
);

    localparam int CW = $clog2(SLOT) + 1;

    logic          flush;
    logic          in_valid;
    logic          in_ready;
    inst_t         in_inst;
    logic          out_valid;
    logic          out_ready;
    inst_t         out_inst;
    logic [CW-1:0] count;

    modport master (
        output flush,
        output in_valid,
        output in_inst,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_inst,
        input  count
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_inst,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_inst,
        output count
    );

endinterface

// File: rtl/inst_slot_queue_mux_write.sv
// rtl/inst_slot_queue_mux_write.sv - slot write-select mux producing the slot array next-state
//
// Purpose : every slot reloads its own value from the feedback array except the
//           one selected by sample_req, which takes data_in when write is high.
// Ports   : data_fb    in  current slot array (registered feedback)
//           data_in    in  instruction to store
//           sample_req in  index of the slot to overwrite
//           write      in  write enable for the selected slot
//           data_out   out slot array next-state
module inst_slot_queue_mux_write
    import inst_slot_queue_pkg::*;
#(
    parameter int SLOT = DEFAULT_SLOT
) (
    input  inst_t [SLOT-1:0]         data_fb,
    input  inst_t                    data_in,
    input  logic [$clog2(SLOT)-1:0]  sample_req,
    input  logic                     write,
    output inst_t [SLOT-1:0]         data_out
);

    always_comb begin
        data_out = data_fb;
        if (write) begin
            data_out[sample_req] = data_in;
        end
    end

endmodule

// File: rtl/inst_slot_queue.sv
// rtl/inst_slot_queue.sv - circular instruction slot queue between fetch and the next stage
//
// Purpose : owns the slot storage array, write/read pointers and occupancy count;
//           drives the write mux select/enable and registers its result back as
//           the feedback array. The oldest entry is presented combinationally.
// Ports   : clk    in  system clock, rising edge
//           rst_n  in  asynchronous active-low reset
//           bus    slave modport: flush, in_valid/in_ready/in_inst,
//                  out_valid/out_ready/out_inst, count
module inst_slot_queue
    import inst_slot_queue_pkg::*;
#(
    parameter int SLOT = DEFAULT_SLOT
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_slot_queue_if.slave   bus
);

    localparam int PW = $clog2(SLOT);
    localparam int CW = PW + 1;

    inst_t [SLOT-1:0] slot_q;
    inst_t [SLOT-1:0] slot_d;
    logic  [PW-1:0]   wptr_q;
    logic  [PW-1:0]   rptr_q;
    logic  [CW-1:0]   count_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Handshake outputs come only from the registered count, so there is no
    // combinational path from in_valid/out_ready. A full queue refuses a push
    // even when a pop happens in the same cycle.
    assign full          = (count_q == CW'(SLOT));
    assign empty         = (count_q == '0);
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_inst  = slot_q[rptr_q];
    assign bus.count     = count_q;

    // A flushed cycle discards both the enqueue and the dequeue.
    assign push = bus.in_valid && !full  && !bus.flush;
    assign pop  = bus.out_ready && !empty && !bus.flush;

    inst_slot_queue_mux_write #(
        .SLOT (SLOT)
    ) u_mux_write (
        .data_fb    (slot_q),
        .data_in    (bus.in_inst),
        .sample_req (wptr_q),
        .write      (push),
        .data_out   (slot_d)
    );

    // Slot contents survive a flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Pointers wrap naturally since SLOT is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule
